mav_ctrl: RTL and testbench

Sequencing controller for the MAV moving-average unit. It turns either a debounced push-button press or a free-running sample timer into single-cycle `en` strobes with a registered sample `d`. It captures MAV's `m` result one cycle after each strobe and qualifies it with a window-fill count. It sits between board I/O (switches, button) and the MAV instance on the lab top level.

---
 rtl/mav_pkg.sv | 15 +
 rtl/mav_sync2.sv | 21 ++
 rtl/mav_ctrl.sv | 149 ++++++++++++++
 tb/tb_mav_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mav_pkg.sv
// Shared constants and FSM state type for the MAV sequencing controller.
package mav_pkg;

  localparam int unsigned MAV_DW  = 16;
  localparam int unsigned MAV_WIN = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    FIRE,
    HOLD,
    RELEASE
  } mav_ctrl_state_t;

endpackage

// File: rtl/mav_sync2.sv
// Two-flop synchronizer for a single asynchronous board input.
module mav_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= din;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mav_ctrl.sv
// MAV sequencer: debounced button or periodic timer issues one-cycle en strobes,
// then captures the MAV result two cycles later and tracks window fill.
module mav_ctrl
  import mav_pkg::*;
#(
  parameter int unsigned DW          = MAV_DW,
  parameter int unsigned WIN         = MAV_WIN,
  parameter int unsigned DB_CYCLES   = 20,
  parameter int unsigned AUTO_PERIOD = 100
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          btn,
  input  logic          mode,
  input  logic [DW-1:0] d_in,
  input  logic [DW-1:0] m,
  output logic          en,
  output logic [DW-1:0] d,
  output logic [DW-1:0] m_out,
  output logic          m_valid,
  output logic [2:0]    fill_cnt,
  output logic [15:0]   sample_cnt
);

  localparam int unsigned CW  = 16;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0]   DB_LIM = CW1'(DB_CYCLES);
  localparam logic [CW-1:0] PER_TC = CW'(AUTO_PERIOD - 1);
  localparam logic [2:0]    WIN_C  = 3'(WIN);
  localparam logic [3:0]    WIN_W  = 4'(WIN);

  logic            btn_s;
  logic            mode_s;
  logic            mode_q;
  logic            en_d;
  logic            db_done;
  logic [CW-1:0]   db_cnt;
  logic [CW-1:0]   per_cnt;
  mav_ctrl_state_t state;

  mav_sync2 u_sync_btn (
    .clk  (clk),
    .rstn (rstn),
    .din  (btn),
    .q    (btn_s)
  );

  mav_sync2 u_sync_mode (
    .clk  (clk),
    .rstn (rstn),
    .din  (mode),
    .q    (mode_s)
  );

  // The entry cycle already counts as one stable sample, hence the +1.
  assign db_done = ({1'b0, db_cnt} + CW1'(1)) >= DB_LIM;

  // Strobe generation: mode change wins, then auto timer, then manual debounce FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      db_cnt     <= '0;
      per_cnt    <= '0;
      mode_q     <= 1'b0;
      en         <= 1'b0;
      d          <= '0;
      sample_cnt <= '0;
    end else begin
      mode_q <= mode_s;
      en     <= 1'b0;
      if (mode_s != mode_q) begin
        state   <= IDLE;
        db_cnt  <= '0;
        per_cnt <= '0;
      end else if (mode_s) begin
        state  <= IDLE;
        db_cnt <= '0;
        if (per_cnt == PER_TC) begin
          per_cnt    <= '0;
          en         <= 1'b1;
          d          <= d_in;
          sample_cnt <= sample_cnt + 16'd1;
        end else begin
          per_cnt <= per_cnt + CW'(1);
        end
      end else begin
        case (state)
          IDLE: begin
            if (btn_s) begin
              state  <= PRESS;
              db_cnt <= CW'(1);
            end
          end
          PRESS: begin
            if (!btn_s) begin
              state <= IDLE;
            end else if (db_done) begin
              state      <= FIRE;
              en         <= 1'b1;
              d          <= d_in;
              sample_cnt <= sample_cnt + 16'd1;
            end else begin
              db_cnt <= db_cnt + CW'(1);
            end
          end
          FIRE: state <= HOLD;
          HOLD: begin
            if (!btn_s) begin
              state  <= RELEASE;
              db_cnt <= CW'(1);
            end
          end
          RELEASE: begin
            if (btn_s) begin
              state <= HOLD;
            end else if (db_done) begin
              state <= IDLE;
            end else begin
              db_cnt <= db_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // MAV result is valid the cycle after en; capture it on the following edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_d     <= 1'b0;
      m_out    <= '0;
      fill_cnt <= '0;
      m_valid  <= 1'b0;
    end else begin
      en_d <= en;
      if (en_d) begin
        m_out <= m;
        if (fill_cnt < WIN_C) begin
          fill_cnt <= fill_cnt + 3'd1;
        end
        if (({1'b0, fill_cnt} + 4'd1) >= WIN_W) begin
          m_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mav_ctrl.sv
// Bench for mav_ctrl: directed scenarios plus random button/mode traffic against a run-length model.
module tb_mav_ctrl;

  localparam int unsigned DW  = 16;
  localparam int unsigned WIN = 4;
  localparam int          DB  = 4;
  localparam int          PER = 10;
  localparam logic [15:0] DSEQ [4] = '{16'd1, 16'd5, 16'd6, 16'd7};
  localparam logic [15:0] MSEQ [4] = '{16'd0, 16'd0, 16'd0, 16'd4};

  logic          clk = 1'b0;
  logic          rstn;
  logic          btn;
  logic          mode;
  logic [DW-1:0] d_in;
  logic [DW-1:0] m;
  logic          en;
  logic [DW-1:0] d;
  logic [DW-1:0] m_out;
  logic          m_valid;
  logic [2:0]    fill_cnt;
  logic [15:0]   sample_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int en_total = 0;

  mav_ctrl #(
    .DW          (DW),
    .WIN         (WIN),
    .DB_CYCLES   (DB),
    .AUTO_PERIOD (PER)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn        (btn),
    .mode       (mode),
    .d_in       (d_in),
    .m          (m),
    .en         (en),
    .d          (d),
    .m_out      (m_out),
    .m_valid    (m_valid),
    .fill_cnt   (fill_cnt),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: synchronizer delay, run lengths of the synchronized button,
  // an armed flag meaning "released long enough", and a cycle count in auto mode.
  bit          b1, b2, m1, m2, mprev;
  bit          armed, skip, h1, h2;
  bit          exp_en, prev_en, exp_valid;
  int          run_hi, run_lo, acnt, exp_fill;
  logic [15:0] exp_d, exp_mout, exp_scnt;

  task automatic model_reset();
    b1 = 0; b2 = 0; m1 = 0; m2 = 0; mprev = 0;
    armed = 1; skip = 0; h1 = 0; h2 = 0;
    exp_en = 0; prev_en = 0; exp_valid = 0;
    run_hi = 0; run_lo = 0; acnt = 0; exp_fill = 0;
    exp_d = '0; exp_mout = '0; exp_scnt = '0;
  endtask

  task automatic model_step();
    bit bs, ms, fire;
    bs = b2; ms = m2;
    b2 = b1; b1 = btn;
    m2 = m1; m1 = mode;
    fire = 0;
    if (ms != mprev) begin
      run_hi = 0; run_lo = 0; armed = 1; skip = 0; acnt = 0;
    end else if (ms) begin
      run_hi = 0; run_lo = 0; armed = 1; skip = 0;
      acnt++;
      if (acnt == PER) begin
        fire = 1;
        acnt = 0;
      end
    end else if (skip) begin
      skip = 0;  // the strobe cycle itself does not look at the button
    end else if (armed) begin
      if (bs) begin
        run_hi++;
        if (run_hi == DB) begin
          fire = 1; armed = 0; skip = 1; run_lo = 0;
        end
      end else begin
        run_hi = 0;
      end
    end else begin
      if (!bs) begin
        run_lo++;
        if (run_lo == DB) begin
          armed = 1; run_hi = 0;
        end
      end else begin
        run_lo = 0;
      end
    end
    mprev = ms;
    if (h2) begin
      exp_mout = m;
      if (exp_fill < int'(WIN)) exp_fill++;
      if (exp_fill >= int'(WIN)) exp_valid = 1;
    end
    h2 = h1; h1 = fire;
    prev_en = exp_en; exp_en = fire;
    if (fire) begin
      exp_d    = d_in;
      exp_scnt = exp_scnt + 16'd1;
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    chk("en", 32'(en), 32'(exp_en));
    chk("d", 32'(d), 32'(exp_d));
    chk("m_out", 32'(m_out), 32'(exp_mout));
    chk("fill_cnt", 32'(fill_cnt), 32'(exp_fill));
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    if (!exp_en && !prev_en) chk("sample_cnt", 32'(sample_cnt), 32'(exp_scnt));
    if (en) en_total <= en_total + 1;
  end

  task automatic chk_cleared(input string tag);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_d"}, 32'(d), 32'd0);
    chk({tag, "_m_out"}, 32'(m_out), 32'd0);
    chk({tag, "_fill"}, 32'(fill_cnt), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_scnt"}, 32'(sample_cnt), 32'd0);
  endtask

  task automatic wait_en(input string tag, input int budget);
    int i;
    i = 0;
    while (!en && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(en), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_cleared("rst_async");
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, first, prev_cyc, found, seg;
    logic [15:0] d_first;

    rstn = 1'b0; btn = 1'b0; mode = 1'b0; d_in = '0; m = '0;

    // 1: reset, then idle with no strobes
    repeat (10) @(negedge clk);
    chk_cleared("t1_reset");
    rstn = 1'b1;
    base = en_total;
    repeat (50) @(negedge clk);
    chk("t1_no_en", 32'(en_total - base), 32'd0);

    // 2: single long press yields one strobe, DB+2 cycles after first sample
    d_in = 16'h0004;
    btn  = 1'b1;
    base = en_total;
    first = 0; d_first = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (en && first == 0) begin
        first   = i;
        d_first = d;
      end
    end
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2_latency", 32'(first), 32'd6);
    chk("t2_d", 32'(d_first), 32'h4);
    chk("t2_count", 32'(en_total - base), 32'd1);
    chk("t2_scnt", 32'(sample_cnt), 32'd1);

    // 3: bounce shorter than the debounce window
    base = en_total;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn = ~btn;
      @(negedge clk);
    end
    btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_no_en", 32'(en_total - base), 32'd0);
    chk("t3_idle", 32'(dut.state), 32'(mav_pkg::IDLE));

    // 4: auto mode from a clean reset
    do_reset(3);
    mode = 1'b1; d_in = DSEQ[0]; m = '0;
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_en("t4_strobe", 30);
      if (k > 0) chk("t4_gap", 32'(cyc - prev_cyc), 32'd10);
      prev_cyc = cyc;
      chk("t4_d", 32'(d), 32'(DSEQ[k]));
      m    = MSEQ[k];
      d_in = DSEQ[(k < 3) ? k + 1 : 3];
      @(negedge clk);
      if (k == 3) chk("t4_valid_early", 32'(m_valid), 32'd0);
      @(negedge clk);
      chk("t4_fill", 32'(fill_cnt), 32'(k + 1));
      if (k == 3) begin
        chk("t4_valid", 32'(m_valid), 32'd1);
        chk("t4_m_out", 32'(m_out), 32'h4);
      end
    end

    // 5: mode glitch while a press is being debounced
    mode = 1'b0; m = '0;
    repeat (20) @(negedge clk);
    base = en_total;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_press", 32'(dut.state), 32'(mav_pkg::PRESS));
    mode = 1'b1;
    @(negedge clk);
    mode = 1'b0;
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      @(negedge clk);
      if (dut.state == mav_pkg::IDLE) found = 1;
    end
    chk("t5_idle", 32'(found), 32'd1);
    chk("t5_switch_en", 32'(en), 32'd0);
    chk("t5_per_cnt", 32'(dut.per_cnt), 32'd0);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_en", 32'(en_total - base), 32'd0);

    // 6: reset lands between strobe and capture
    mode = 1'b1; m = 16'hBEEF;
    wait_en("t6_strobe", 30);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_cleared("t6_async");
    repeat (3) @(negedge clk);
    mode = 1'b0;
    rstn = 1'b1;
    base = en_total;
    repeat (30) @(negedge clk);
    chk("t6_no_en", 32'(en_total - base), 32'd0);
    chk("t6_fill", 32'(fill_cnt), 32'd0);

    // Random button/mode traffic against the model
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      d_in = 16'($urandom);
      m    = 16'($urandom);
      if (seg == 0) begin
        btn = ~btn;
        seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
      end else begin
        seg--;
      end
      if ($urandom_range(0, 299) == 0) mode = ~mode;
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
